// File: rtl/qspi_sram_responder.sv
// qspi_sram_responder: quad-mode SPI-RAM target (READ 0x03 / WRITE 0x02).
// Turns each CS-framed SQI transaction into byte accesses on a simple
// synchronous memory port. SCK is oversampled by clk and must hold each
// level for at least 4 clk.
module qspi_sram_responder #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DUMMY_SCK   = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  qspi_cs_n_i,
    input  logic                  qspi_sck_i,
    input  logic [3:0]            qspi_sio_i,
    output logic [3:0]            qspi_sio_o,
    output logic                  qspi_sio_oe,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [7:0]            mem_wdata,
    output logic                  mem_re,
    input  logic [7:0]            mem_rdata,
    output logic                  busy,
    output logic                  cmd_err
);

    typedef enum logic [2:0] {
        IDLE, CMD, IGNORE, ADDR, DUMMY, RDATA, WDATA
    } state_t;

    // Synchronizer chains; the last stage is the usable sample.
    logic [SYNC_STAGES-1:0] cs_sync_reg;
    logic [SYNC_STAGES-1:0] sck_sync_reg;
    logic [3:0]             sio_sync_reg [SYNC_STAGES];

    logic       cs_s, sck_s, sck_rise, sck_fall;
    logic [3:0] sio_s;
    logic       cs_prev_reg, sck_prev_reg;

    state_t                state_reg, state_next;
    logic [7:0]            cnt_reg, cnt_next;
    logic                  half_reg, half_next;
    logic                  rd_reg, rd_next;
    logic [11:0]           shift_reg, shift_next;
    logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic [7:0]            prefetch_reg, prefetch_next;
    logic [3:0]            sio_o_reg, sio_o_next;
    logic                  oe_reg, oe_next;
    logic                  we_reg, we_next;
    logic [7:0]            wdata_reg, wdata_next;
    logic                  re_reg, re_next;
    logic                  re_d_reg, re_d_next;
    logic                  err_reg, err_next;

    logic [7:0]  opcode;
    logic [15:0] addr_new;

    // Shift raw inputs through the synchronizer stages (idle: cs_n=1, sck=0).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cs_sync_reg  <= '1;
            sck_sync_reg <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) sio_sync_reg[i] <= '0;
            cs_prev_reg  <= 1'b1;
            sck_prev_reg <= 1'b0;
        end else begin
            cs_sync_reg[0]  <= qspi_cs_n_i;
            sck_sync_reg[0] <= qspi_sck_i;
            sio_sync_reg[0] <= qspi_sio_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                cs_sync_reg[i]  <= cs_sync_reg[i-1];
                sck_sync_reg[i] <= sck_sync_reg[i-1];
                sio_sync_reg[i] <= sio_sync_reg[i-1];
            end
            cs_prev_reg  <= cs_s;
            sck_prev_reg <= sck_s;
        end
    end

    assign cs_s     = cs_sync_reg[SYNC_STAGES-1];
    assign sck_s    = sck_sync_reg[SYNC_STAGES-1];
    assign sio_s    = sio_sync_reg[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev_reg;
    assign sck_fall = ~sck_s & sck_prev_reg;
    assign opcode   = {shift_reg[3:0], sio_s};
    assign addr_new = {shift_reg, sio_s};

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            half_reg     <= 1'b0;
            rd_reg       <= 1'b0;
            shift_reg    <= '0;
            addr_reg     <= '0;
            prefetch_reg <= '0;
            sio_o_reg    <= '0;
            oe_reg       <= 1'b0;
            we_reg       <= 1'b0;
            wdata_reg    <= '0;
            re_reg       <= 1'b0;
            re_d_reg     <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            half_reg     <= half_next;
            rd_reg       <= rd_next;
            shift_reg    <= shift_next;
            addr_reg     <= addr_next;
            prefetch_reg <= prefetch_next;
            sio_o_reg    <= sio_o_next;
            oe_reg       <= oe_next;
            we_reg       <= we_next;
            wdata_reg    <= wdata_next;
            re_reg       <= re_next;
            re_d_reg     <= re_d_next;
            err_reg      <= err_next;
        end
    end

    // Next-state, nibble assembly, strobes and output nibble sequencing.
    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        half_next     = half_reg;
        rd_next       = rd_reg;
        shift_next    = shift_reg;
        addr_next     = addr_reg;
        prefetch_next = prefetch_reg;
        sio_o_next    = sio_o_reg;
        oe_next       = oe_reg;
        we_next       = 1'b0;
        wdata_next    = wdata_reg;
        re_next       = 1'b0;
        re_d_next     = re_reg;
        err_next      = 1'b0;

        // Read data is valid the clk after mem_re; latch it as the prefetch byte.
        if (re_d_reg) prefetch_next = mem_rdata;
        // A write lands at the current address, then the address advances.
        if (we_reg) addr_next = addr_reg + ADDR_WIDTH'(1);

        case (state_reg)
            IDLE: begin
                if (!cs_s && cs_prev_reg) begin
                    state_next = CMD;
                    cnt_next   = '0;
                end
            end
            CMD: begin
                if (sck_rise) begin
                    shift_next = {shift_reg[7:0], sio_s};
                    cnt_next   = cnt_reg + 8'd1;
                    if (cnt_reg == 8'd1) begin
                        cnt_next = '0;
                        if (opcode == 8'h03) begin
                            rd_next    = 1'b1;
                            state_next = ADDR;
                        end else if (opcode == 8'h02) begin
                            rd_next    = 1'b0;
                            state_next = ADDR;
                        end else begin
                            err_next   = 1'b1;
                            state_next = IGNORE;
                        end
                    end
                end
            end
            IGNORE: begin
                state_next = IGNORE;
            end
            ADDR: begin
                if (sck_rise) begin
                    shift_next = {shift_reg[7:0], sio_s};
                    cnt_next   = cnt_reg + 8'd1;
                    if (cnt_reg == 8'd3) begin
                        addr_next = addr_new[ADDR_WIDTH-1:0];
                        cnt_next  = '0;
                        half_next = 1'b0;
                        if (rd_reg) begin
                            re_next    = 1'b1;
                            state_next = DUMMY;
                        end else begin
                            state_next = WDATA;
                        end
                    end
                end
            end
            DUMMY: begin
                if (sck_rise && cnt_reg != 8'(DUMMY_SCK)) cnt_next = cnt_reg + 8'd1;
                if (sck_fall && cnt_reg == 8'(DUMMY_SCK)) begin
                    oe_next    = 1'b1;
                    sio_o_next = prefetch_reg[7:4];
                    half_next  = 1'b0;
                    state_next = RDATA;
                end
            end
            RDATA: begin
                if (sck_fall) begin
                    if (!half_reg) begin
                        sio_o_next = prefetch_reg[3:0];
                        addr_next  = addr_reg + ADDR_WIDTH'(1);
                        re_next    = 1'b1;
                        half_next  = 1'b1;
                    end else begin
                        sio_o_next = prefetch_reg[7:4];
                        half_next  = 1'b0;
                    end
                end
            end
            WDATA: begin
                if (sck_rise) begin
                    if (!half_reg) begin
                        shift_next = {shift_reg[7:0], sio_s};
                        half_next  = 1'b1;
                    end else begin
                        we_next    = 1'b1;
                        wdata_next = {shift_reg[3:0], sio_s};
                        half_next  = 1'b0;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // CS high aborts from any state; a half-received write byte is dropped.
        if (cs_s && state_reg != IDLE) begin
            state_next = IDLE;
            oe_next    = 1'b0;
            sio_o_next = '0;
            we_next    = 1'b0;
            re_next    = 1'b0;
            half_next  = 1'b0;
        end
    end

    assign qspi_sio_o  = sio_o_reg;
    assign qspi_sio_oe = oe_reg;
    assign mem_addr    = addr_reg;
    assign mem_we      = we_reg;
    assign mem_wdata   = wdata_reg;
    assign mem_re      = re_reg;
    assign cmd_err     = err_reg;
    assign busy        = ~cs_s;

endmodule

// File: tb/tb_qspi_sram_responder.sv
// Testbench for qspi_sram_responder: drives SQI transactions as the initiator,
// serves a byte memory, and checks reads/writes against a reference memory.
module tb_qspi_sram_responder;

    localparam int DUMMY = 2;
    localparam int HDR   = 6;   // opcode + address nibbles

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cs_n = 1'b1;
    logic        sck = 1'b0;
    logic [3:0]  sio_i = 4'h0;
    logic [3:0]  sio_o;
    logic        sio_oe;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic        mem_re;
    logic [7:0]  mem_rdata = 8'h00;
    logic        busy;
    logic        cmd_err;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    qspi_sram_responder #(
        .ADDR_WIDTH (16),
        .DUMMY_SCK  (DUMMY),
        .SYNC_STAGES(2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .qspi_cs_n_i(cs_n),
        .qspi_sck_i (sck),
        .qspi_sio_i (sio_i),
        .qspi_sio_o (sio_o),
        .qspi_sio_oe(sio_oe),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_re     (mem_re),
        .mem_rdata  (mem_rdata),
        .busy       (busy),
        .cmd_err    (cmd_err)
    );

    // Memory served to the DUT, and the bench's own expectation of its contents.
    logic [7:0] mem     [65536];
    logic [7:0] ref_mem [65536];

    always @(posedge clk) begin
        if (mem_re) mem_rdata <= mem[mem_addr];
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    // Strobe monitor.
    int we_cnt = 0, re_cnt = 0, err_cnt = 0, both_cnt = 0;
    logic [15:0] wlog_addr[$];
    logic [7:0]  wlog_data[$];

    always @(posedge clk) begin
        if (!reset) begin
            if (mem_we) begin
                we_cnt++;
                wlog_addr.push_back(mem_addr);
                wlog_data.push_back(mem_wdata);
            end
            if (mem_re) re_cnt++;
            if (cmd_err) err_cnt++;
            if (mem_we && mem_re) both_cnt++;
        end
    end

    logic [3:0] rx_nib[$];
    logic       rx_oe[$];
    logic [7:0] wbytes[$];

    // ---------------- initiator primitives ----------------
    task automatic sck_cycle(input logic [3:0] nib);
        sio_i = nib;
        repeat (5) @(negedge clk);
        sck = 1'b1;
        rx_nib.push_back(sio_o);
        rx_oe.push_back(sio_oe);
        repeat (5) @(negedge clk);
        sck = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        sck_cycle(b[7:4]);
        sck_cycle(b[3:0]);
    endtask

    task automatic cs_begin();
        rx_nib.delete();
        rx_oe.delete();
        @(negedge clk);
        cs_n = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic cs_end();
        repeat (5) @(negedge clk);
        cs_n = 1'b1;
    endtask

    task automatic idle();
        repeat (8) @(negedge clk);
    endtask

    // Write nnib data nibbles taken from wbytes; the model stores only whole bytes.
    task automatic do_write(input logic [15:0] addr, input int nnib);
        logic [7:0]  b;
        logic [15:0] a;
        wlog_addr.delete();
        wlog_data.delete();
        cs_begin();
        send_byte(8'h02);
        send_byte(addr[15:8]);
        send_byte(addr[7:0]);
        for (int i = 0; i < nnib; i++) begin
            b = wbytes[i/2];
            sck_cycle((i % 2 == 0) ? b[7:4] : b[3:0]);
        end
        cs_end();
        for (int i = 0; i < nnib / 2; i++) begin
            a = addr + 16'(i);
            ref_mem[a] = wbytes[i];
        end
    endtask

    task automatic do_read(input logic [15:0] addr, input int nnib);
        cs_begin();
        send_byte(8'h03);
        send_byte(addr[15:8]);
        send_byte(addr[7:0]);
        for (int i = 0; i < DUMMY; i++) sck_cycle(4'($urandom_range(15)));
        for (int i = 0; i < nnib; i++) sck_cycle(4'h0);
        cs_end();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (3) @(negedge clk);
        tests++; if (sio_oe !== 1'b0)    begin fails++; $display("FAIL reset_oe got %b exp 0", sio_oe); end
        tests++; if (sio_o !== 4'h0)     begin fails++; $display("FAIL reset_sio_o got %h exp 0", sio_o); end
        tests++; if (mem_we !== 1'b0)    begin fails++; $display("FAIL reset_we got %b exp 0", mem_we); end
        tests++; if (mem_re !== 1'b0)    begin fails++; $display("FAIL reset_re got %b exp 0", mem_re); end
        tests++; if (mem_addr !== 16'h0) begin fails++; $display("FAIL reset_addr got %h exp 0", mem_addr); end
        tests++; if (busy !== 1'b0)      begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
        tests++; if (cmd_err !== 1'b0)   begin fails++; $display("FAIL reset_err got %b exp 0", cmd_err); end
        reset = 1'b0;
        repeat (4) @(negedge clk);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL idle_busy got %b exp 0", busy); end
        $display("[TB] reset checked");
    endtask

    task automatic test_write_basic();
        int we0 = we_cnt, re0 = re_cnt;
        wbytes = '{8'hA5, 8'h3C};
        do_write(16'h0010, 4);
        idle();
        tests++; if (we_cnt - we0 != 2) begin fails++; $display("FAIL wr_count got %0d exp 2", we_cnt - we0); end
        tests++; if (re_cnt != re0) begin fails++; $display("FAIL wr_no_re got %0d exp 0", re_cnt - re0); end
        if (wlog_addr.size() == 2) begin
            tests++; if (wlog_addr[0] !== 16'h0010 || wlog_data[0] !== 8'hA5) begin fails++; $display("FAIL wr0 got %h:%h exp 0010:a5", wlog_addr[0], wlog_data[0]); end
            tests++; if (wlog_addr[1] !== 16'h0011 || wlog_data[1] !== 8'h3C) begin fails++; $display("FAIL wr1 got %h:%h exp 0011:3c", wlog_addr[1], wlog_data[1]); end
        end
        $display("[TB] write 0x0010 A5 3C: %0d strobes", we_cnt - we0);
    endtask

    task automatic test_read_basic();
        logic [3:0] exp_n [4];
        int re0 = re_cnt;
        exp_n = '{4'hA, 4'h5, 4'h3, 4'hC};
        do_read(16'h0010, 4);
        busy_wait_oe();
        idle();
        for (int k = 0; k < HDR + DUMMY + 4; k++) begin
            tests++;
            if (rx_oe[k] !== (k >= HDR + DUMMY)) begin
                fails++; $display("FAIL rd_oe cycle %0d got %b exp %b", k, rx_oe[k], (k >= HDR + DUMMY));
            end
        end
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (rx_nib[HDR + DUMMY + k] !== exp_n[k]) begin
                fails++; $display("FAIL rd_nib %0d got %h exp %h", k, rx_nib[HDR + DUMMY + k], exp_n[k]);
            end
        end
        tests++; if (re_cnt - re0 != 3) begin fails++; $display("FAIL rd_re_count got %0d exp 3", re_cnt - re0); end
        $display("[TB] read 0x0010 x4 nibbles: %h%h%h%h", rx_nib[HDR+DUMMY], rx_nib[HDR+DUMMY+1], rx_nib[HDR+DUMMY+2], rx_nib[HDR+DUMMY+3]);
    endtask

    // oe must be released within 3 clk of CS going high.
    task automatic busy_wait_oe();
        repeat (3) @(posedge clk);
        #1;
        tests++; if (sio_oe !== 1'b0) begin fails++; $display("FAIL oe_release got %b exp 0", sio_oe); end
    endtask

    // Read nnib nibbles from addr and compare against the reference memory.
    task automatic check_read(input logic [15:0] addr, input int nnib, input string tag);
        logic [15:0] a;
        logic [7:0]  b;
        logic [3:0]  e;
        int bad = 0;
        do_read(addr, nnib);
        idle();
        for (int k = 0; k < nnib; k++) begin
            a = addr + 16'(k / 2);
            b = ref_mem[a];
            e = (k % 2 == 0) ? b[7:4] : b[3:0];
            tests++;
            if (rx_nib[HDR + DUMMY + k] !== e || rx_oe[HDR + DUMMY + k] !== 1'b1) begin
                fails++; bad++;
                $display("FAIL %s nib %0d addr %h got %h oe %b exp %h", tag, k, a, rx_nib[HDR + DUMMY + k], rx_oe[HDR + DUMMY + k], e);
            end
        end
        $display("[TB] %s read %h x%0d nibbles, %0d bad", tag, addr, nnib, bad);
    endtask

    task automatic test_wrap();
        wbytes = '{8'h11, 8'h22};
        do_write(16'hFFFF, 4);
        idle();
        tests++; if (wlog_addr.size() != 2) begin fails++; $display("FAIL wrap_count got %0d exp 2", wlog_addr.size()); end
        if (wlog_addr.size() == 2) begin
            tests++; if (wlog_addr[0] !== 16'hFFFF || wlog_data[0] !== 8'h11) begin fails++; $display("FAIL wrap_wr0 got %h:%h exp ffff:11", wlog_addr[0], wlog_data[0]); end
            tests++; if (wlog_addr[1] !== 16'h0000 || wlog_data[1] !== 8'h22) begin fails++; $display("FAIL wrap_wr1 got %h:%h exp 0000:22", wlog_addr[1], wlog_data[1]); end
        end
        check_read(16'hFFFF, 4, "wrap");
    endtask

    task automatic test_bad_opcode();
        int we0 = we_cnt, re0 = re_cnt, e0 = err_cnt;
        int oe_hi = 0;
        cs_begin();
        send_byte(8'h05);
        for (int i = 0; i < 4; i++) send_byte(8'($urandom_range(255)));
        cs_end();
        idle();
        foreach (rx_oe[k]) if (rx_oe[k] !== 1'b0) oe_hi++;
        tests++; if (err_cnt - e0 != 1) begin fails++; $display("FAIL bad_op_err got %0d exp 1", err_cnt - e0); end
        tests++; if (we_cnt != we0 || re_cnt != re0) begin fails++; $display("FAIL bad_op_mem got we %0d re %0d exp 0 0", we_cnt - we0, re_cnt - re0); end
        tests++; if (oe_hi != 0) begin fails++; $display("FAIL bad_op_oe got %0d oe samples high exp 0", oe_hi); end
        $display("[TB] opcode 05: cmd_err x%0d", err_cnt - e0);
        check_read(16'($urandom_range(65535)), 4, "after_bad_op");
    endtask

    task automatic test_partial_write();
        logic [15:0] a = 16'($urandom_range(16'hFFF0));
        int we0 = we_cnt;
        wbytes = '{8'($urandom_range(255)), 8'($urandom_range(255))};
        do_write(a, 3);
        idle();
        tests++; if (we_cnt - we0 != 1) begin fails++; $display("FAIL partial_count got %0d exp 1", we_cnt - we0); end
        if (wlog_addr.size() == 1) begin
            tests++; if (wlog_addr[0] !== a || wlog_data[0] !== wbytes[0]) begin fails++; $display("FAIL partial_wr got %h:%h exp %h:%h", wlog_addr[0], wlog_data[0], a, wbytes[0]); end
        end
        $display("[TB] partial write %h: %0d strobes", a, we_cnt - we0);
        check_read(a, 4, "partial");
    endtask

    task automatic test_zero_data();
        int we0 = we_cnt;
        wbytes.delete();
        do_write(16'($urandom_range(65535)), 0);
        idle();
        tests++; if (we_cnt != we0) begin fails++; $display("FAIL zero_data got %0d strobes exp 0", we_cnt - we0); end
        $display("[TB] zero-data write: %0d strobes", we_cnt - we0);
    endtask

    task automatic test_reset_mid_read();
        int bad_oe = 0;
        cs_begin();
        send_byte(8'h03);
        send_byte(8'h12);
        send_byte(8'h34);
        for (int i = 0; i < DUMMY + 3; i++) sck_cycle(4'h0);
        repeat (2) @(negedge clk);
        sck = 1'b1;
        #2 reset = 1'b1;
        #1;
        tests++; if (sio_oe !== 1'b0) begin fails++; $display("FAIL rst_mid_oe got %b exp 0", sio_oe); end
        tests++; if (mem_re !== 1'b0 || mem_we !== 1'b0) begin fails++; $display("FAIL rst_mid_strobe got re %b we %b exp 0 0", mem_re, mem_we); end
        for (int i = 0; i < 6; i++) begin
            repeat (5) @(negedge clk);
            sck = ~sck;
            if (sio_oe !== 1'b0) bad_oe++;
        end
        sck = 1'b0;
        tests++; if (bad_oe != 0) begin fails++; $display("FAIL rst_hold_oe got %0d high samples exp 0", bad_oe); end
        cs_n = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        $display("[TB] reset mid-read: oe released");
        check_read(16'h0000, 4, "after_reset");
    endtask

    task automatic test_random();
        logic [15:0] a;
        int nb;
        for (int it = 0; it < 6; it++) begin
            a  = (it % 3 == 0) ? 16'(16'hFFFE + $urandom_range(1)) : 16'($urandom_range(65535));
            nb = $urandom_range(1, 4);
            wbytes.delete();
            for (int i = 0; i < nb; i++) wbytes.push_back(8'($urandom_range(255)));
            do_write(a, 2 * nb);
            idle();
            tests++; if (wlog_addr.size() != nb) begin fails++; $display("FAIL rand_wr_count got %0d exp %0d", wlog_addr.size(), nb); end
            $display("[TB] random write %h x%0d bytes", a, nb);
            check_read(a, 2 * $urandom_range(1, 5), "random");
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem[i]     = 8'($urandom_range(255));
            ref_mem[i] = mem[i];
        end
        test_reset();
        test_write_basic();
        test_read_basic();
        test_wrap();
        test_bad_opcode();
        test_partial_write();
        test_zero_data();
        test_reset_mid_read();
        test_random();
        tests++; if (both_cnt != 0) begin fails++; $display("FAIL re_we_overlap got %0d exp 0", both_cnt); end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/qspi_sram_responder.md
Name: qspi_sram_responder

Overview:
- Synthesizable SQI (quad-mode) SPI-RAM responder: the target end of the QSPI link the bfCPU chip drives as initiator.
- Decodes a 23LC512-compatible command subset (READ 0x03, WRITE 0x02) arriving on CS_N/SCK/SIO[3:0].
- Converts each transaction into byte accesses on a simple synchronous memory port.
- Used on FPGA bring-up boards and in benches in place of the external SRAM.

Parameters:
- ADDR_WIDTH, 16, byte address width; the address phase is always 16 bits, and the upper bits are truncated if ADDR_WIDTH < 16.
- DUMMY_SCK, 2, SCK cycles of dummy between the last address nibble and the first read data nibble.
- SYNC_STAGES, 2, flip-flop synchronizer depth on cs_n, sck and sio inputs.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- qspi_cs_n_i  input  1  chip select from initiator, active low
- qspi_sck_i  input  1  serial clock from initiator, mode 0 (idle low)
- qspi_sio_i  input  4  SIO[3:0] input path
- qspi_sio_o  output  4  SIO[3:0] output data
- qspi_sio_oe  output  1  SIO output enable, 1 = drive all four lines
- mem_addr  output  ADDR_WIDTH  byte address
- mem_we  output  1  one-clk write strobe
- mem_wdata  output  8  write byte
- mem_re  output  1  one-clk read strobe
- mem_rdata  input  8  read byte, valid exactly 1 clk after mem_re
- busy  output  1  CS active (synchronized cs_n low)
- cmd_err  output  1  one-clk pulse when an unsupported opcode is received

Behaviour:
- Reset, asynchronous: all outputs 0, state IDLE, synchronizers set to cs_n=1, sck=0.
- Input timing: all inputs pass through SYNC_STAGES flip-flops. SCK rise and fall are detected on the synchronized signal.
- Legal SCK timing: high and low times must each be at least 4 clk. Behaviour is undefined for faster SCK.
- Bit order: on each SCK rise one nibble is sampled, high nibble of each byte first.
- Output timing: output nibbles change only on the clk following a detected SCK fall.
- CS deassert: synchronized cs_n=1 forces IDLE from any state, regardless of nibble alignment.
  - qspi_sio_oe drops on that same clk.
  - A partially received write byte is discarded.
- State machine:
  - IDLE -> CMD on synchronized cs_n fall; nibble counter cleared.
  - CMD: 2 rises. 0x03 -> ADDR(rd); 0x02 -> ADDR(wr); any other opcode -> pulse cmd_err, go to IGNORE.
  - IGNORE: hold until CS high. oe stays 0; no memory access.
  - ADDR: 4 rises assemble a 16-bit address.
    - Read: mem_re pulses on the clk after the 4th rise (prefetch), then go to DUMMY.
    - Write: go to WDATA.
  - DUMMY: count DUMMY_SCK rises. On the fall after the last one, assert oe and drive rdata[7:4] (from the prefetch register), then go to RDATA.
  - RDATA: each SCK fall alternates rdata[3:0] and then the next byte's [7:4].
    - When the low nibble goes out, the address increments and mem_re pulses to prefetch the next byte.
    - The prefetched byte lands before the next byte's high-nibble fall, guaranteed by the 4-clk minimum SCK timing.
  - WDATA: every 2nd rise completes a byte.
    - mem_we pulses for 1 clk with mem_wdata = {hi,lo} at the current address.
    - The address then increments.
- Address wrap: increments are modulo 2^16 (0xFFFF -> 0x0000) for both reads and writes. Sequential mode only; no page wrap.
- mem_re and mem_we are never asserted in the same clk.
- busy tracks synchronized cs_n inverted.
- Reset mid-transaction: immediate return to IDLE with oe=0. Transactions resume only after a fresh CS fall.
- Zero-data transactions: CS high directly after the address phase ends cleanly with no mem_we.

Test Plan:
1. Write 0x02, addr 0x0010, bytes 0xA5 0x3C, then CS high -> mem_we pulses twice: (0x0010, 0xA5), (0x0011, 0x3C).
2. Read 0x03, addr 0x0010, 2 dummy SCK, 4 data SCK, memory model returns the written bytes -> initiator samples nibbles A,5,3,C; oe=1 only in the data phase, 0 within 3 clk of CS high.
3. Write 0x02 at addr 0xFFFF with bytes 0x11 0x22 -> writes to 0xFFFF then 0x0000. Read back from 0xFFFF returns 0x11, 0x22.
4. Opcode 0x05 -> cmd_err pulses once, no mem_re/mem_we, oe stays 0 until CS high; a following READ transaction works normally.
5. Write transaction, CS high after 3 data nibbles -> exactly one mem_we (first byte); the trailing nibble is discarded.
6. Assert reset mid-RDATA with SCK still toggling -> oe=0 and all strobes 0 immediately; after release plus a new CS fall, a READ of addr 0x0000 returns correct data.
